// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_e      : controller states (IDLE, CALC, DONE)
//   booth_op_e   : operation selected by one radix-2 Booth step
//   booth_decode : maps {Q[0], q-1} onto the Booth operation
package booth_seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // 01 -> end of a run of ones: add M; 10 -> start of a run: subtract M.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Start/busy/done handshake bundle for booth_seq_multiplier.
//   i_start         : request, taken only while the multiplier is not busy
//   iv_multiplicand : signed M, captured on the accepting edge
//   iv_multiplier   : signed Q, captured on the accepting edge
//   o_busy          : high while iterating
//   o_done          : one-cycle pulse when ov_product is valid
//   ov_product      : signed full-width product, held until the next completion
// master = requester side, slave = multiplier side.
interface booth_seq_multiplier_if #(
  parameter int DATA_WIDTH = 16
);

  logic                      i_start;
  logic [DATA_WIDTH-1:0]     iv_multiplicand;
  logic [DATA_WIDTH-1:0]     iv_multiplier;
  logic                      o_busy;
  logic                      o_done;
  logic [2*DATA_WIDTH-1:0]   ov_product;

  modport master (
    output i_start, iv_multiplicand, iv_multiplier,
    input  o_busy, o_done, ov_product
  );

  modport slave (
    input  i_start, iv_multiplicand, iv_multiplier,
    output o_busy, o_done, ov_product
  );

endinterface

// File: rtl/booth_seq_multiplier_cla.sv
// carry_lookahead_adder: purely combinational WIDTH-bit adder with carry in.
//   i_a, i_b : addends
//   i_cin    : carry into bit 0
//   o_sum    : WIDTH-bit sum; the final carry out is not produced because
//              the Booth accumulator never needs it
module carry_lookahead_adder #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH-1:0] carry;

  // Carries from generate (a&b) and propagate (a^b) terms; synthesis is free
  // to flatten this recurrence into lookahead groups.
  always_comb begin
    carry    = '0;
    carry[0] = i_cin;
    for (int i = 0; i < WIDTH - 1; i++) begin
      carry[i+1] = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & carry[i]);
    end
  end

  assign o_sum = i_a ^ i_b ^ carry;

endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: iterative radix-2 Booth signed multiplier that reuses
// one (DATA_WIDTH+1)-bit carry_lookahead_adder for DATA_WIDTH cycles.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of booth_seq_multiplier_if (start/operands in,
//             busy/done/product out)
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  booth_seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH:0]     m_q, m_d;
  logic [DATA_WIDTH:0]     a_q, a_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    qm1_q, qm1_d;
  logic [CW-1:0]           count_q, count_d;
  logic [2*DATA_WIDTH-1:0] product_q, product_d;

  booth_op_e               op;
  logic [DATA_WIDTH:0]     add_b;
  logic                    add_cin;
  logic [DATA_WIDTH:0]     sum;
  logic                    accept;
  logic                    last_step;

  // A request is taken in IDLE and in DONE (back-to-back), never in CALC.
  assign accept    = bus.i_start && (state_q != CALC);
  assign last_step = (state_q == CALC) && (count_q == CW'(DATA_WIDTH - 1));

  // State register together with the datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_start) state_d = CALC;
      CALC:    if (last_step)   state_d = DONE;
      DONE:    state_d = bus.i_start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // b-select mux feeding the shared adder; subtract is ~M with carry in.
  always_comb begin
    op      = booth_decode(q_q[0], qm1_q);
    add_b   = '0;
    add_cin = 1'b0;
    case (op)
      OP_ADD:  add_b = m_q;
      OP_SUB:  begin
        add_b   = ~m_q;
        add_cin = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  carry_lookahead_adder #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_adder (
    .i_a   (a_q),
    .i_b   (add_b),
    .i_cin (add_cin),
    .o_sum (sum)
  );

  // Operand capture and the Booth step. The shift moves {sum, Q, q-1} right
  // by one with sum's MSB replicated, so the final product is simply
  // {sum, Q[DATA_WIDTH-1:1]} of the last step.
  always_comb begin
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;
    if (accept) begin
      m_d     = {bus.iv_multiplicand[DATA_WIDTH-1], bus.iv_multiplicand};
      q_d     = bus.iv_multiplier;
      a_d     = '0;
      qm1_d   = 1'b0;
      count_d = '0;
    end else if (state_q == CALC) begin
      a_d     = {sum[DATA_WIDTH], sum[DATA_WIDTH:1]};
      q_d     = {sum[0], q_q[DATA_WIDTH-1:1]};
      qm1_d   = q_q[0];
      count_d = count_q + CW'(1);
      if (last_step) begin
        product_d = {sum, q_q[DATA_WIDTH-1:1]};
      end
    end
  end

  // Outputs come straight from registers.
  assign bus.o_busy     = (state_q == CALC);
  assign bus.o_done     = (state_q == DONE);
  assign bus.ov_product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard testbench for booth_seq_multiplier at DATA_WIDTH = 8.
// Stimulus pushes hand-computed products into a queue; an independent
// monitor pops and compares on every o_done pulse.
module tb_booth_seq_multiplier;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  booth_seq_multiplier_if #(.DATA_WIDTH(W)) bus ();

  booth_seq_multiplier #(.DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int pushCount = 0;
  int doneCount = 0;
  logic [2*W-1:0] expQ[$];
  logic [2*W-1:0] prevProduct = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison; every mismatch produces a single FAIL line.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: each done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.o_done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        checkOutput("product", bus.ov_product, expQ.pop_front());
      end
    end
  end

  // Drive a request for one edge, then scramble the operands so that only
  // the accepting edge can have captured them.
  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q,
                               input logic [2*W-1:0] expected, input bit push);
    @(negedge clk);
    bus.i_start         = 1'b1;
    bus.iv_multiplicand = m;
    bus.iv_multiplier   = q;
    if (push) begin
      expQ.push_back(expected);
      pushCount++;
    end
    @(posedge clk);
    #1;
    bus.i_start         = 1'b0;
    bus.iv_multiplicand = ~m;
    bus.iv_multiplier   = ~q;
  endtask

  // Wait (bounded) for o_done, counting edges, busy cycles and cycles where
  // the held product differs from holdVal.
  task automatic waitDone(input logic [2*W-1:0] holdVal, output int edges,
                          output int busyCycles, output int holdErr,
                          output bit seen);
    edges = 0; busyCycles = 0; holdErr = 0; seen = 1'b0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      if (bus.o_done) begin
        seen = 1'b1;
      end else begin
        if (bus.o_busy) busyCycles++;
        if (bus.ov_product !== holdVal) holdErr++;
        @(posedge clk);
        edges++;
      end
    end
  endtask

  task automatic runVector(input string name, input logic [W-1:0] m,
                           input logic [W-1:0] q, input logic [2*W-1:0] expected);
    int edges, busyCycles, holdErr;
    bit seen;
    applyStimulus(m, q, expected, 1'b1);
    waitDone(prevProduct, edges, busyCycles, holdErr, seen);
    checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
    checkOutput({name, "_latency"}, 64'(edges), 64'd8);
    checkOutput({name, "_busy_cycles"}, 64'(busyCycles), 64'd8);
    checkOutput({name, "_held_errs"}, 64'(holdErr), 64'd0);
    prevProduct = expected;
    @(negedge clk);
    checkOutput({name, "_done_width"}, 64'(bus.o_done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges, busyCycles, holdErr, strayDone;
    bit seen;

    rst_n               = 1'b0;
    bus.i_start         = 1'b0;
    bus.iv_multiplicand = '0;
    bus.iv_multiplier   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("reset_done", 64'(bus.o_done), 64'd0);
    checkOutput("reset_product", 64'(bus.ov_product), 64'd0);
    rst_n = 1'b1;

    runVector("p3x5",     8'h03, 8'h05, 16'h000F);
    runVector("m3x5",     8'hFD, 8'h05, 16'hFFF1);
    runVector("p7xm1",    8'h07, 8'hFF, 16'hFFF9);
    runVector("m128xm128",8'h80, 8'h80, 16'h4000);
    runVector("m128x127", 8'h80, 8'h7F, 16'hC080);
    runVector("p0xm77",   8'h00, 8'hB3, 16'h0000);

    // Back-to-back: new request presented during the DONE cycle.
    applyStimulus(8'h05, 8'h06, 16'h001E, 1'b1);
    waitDone(prevProduct, edges, busyCycles, holdErr, seen);
    checkOutput("b2b_first_done", 64'(seen), 64'd1);
    bus.i_start         = 1'b1;
    bus.iv_multiplicand = 8'h0C;
    bus.iv_multiplier   = 8'h0C;
    expQ.push_back(16'h0090);
    pushCount++;
    @(posedge clk);
    #1;
    bus.i_start         = 1'b0;
    bus.iv_multiplicand = 8'hA5;
    bus.iv_multiplier   = 8'h5A;
    waitDone(16'h001E, edges, busyCycles, holdErr, seen);
    checkOutput("b2b_second_done", 64'(seen), 64'd1);
    checkOutput("b2b_gap", 64'(edges + 1), 64'd9);
    checkOutput("b2b_held_errs", 64'(holdErr), 64'd0);
    prevProduct = 16'h0090;
    @(negedge clk);

    // Start pulsed mid-calculation with other operands must be ignored.
    applyStimulus(8'h11, 8'h03, 16'h0033, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.i_start         = 1'b1;
    bus.iv_multiplicand = 8'h7F;
    bus.iv_multiplier   = 8'h7F;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    waitDone(prevProduct, edges, busyCycles, holdErr, seen);
    checkOutput("ignore_done", 64'(seen), 64'd1);
    checkOutput("ignore_latency", 64'(edges), 64'd5);
    checkOutput("ignore_busy_cycles", 64'(busyCycles), 64'd5);
    prevProduct = 16'h0033;
    @(negedge clk);

    // Reset during iteration 4 aborts without a done pulse.
    applyStimulus(8'h19, 8'h05, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("abort_done", 64'(bus.o_done), 64'd0);
    checkOutput("abort_product", 64'(bus.ov_product), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    strayDone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_done) strayDone++;
    end
    checkOutput("abort_no_done", 64'(strayDone), 64'd0);
    prevProduct = '0;
    runVector("p2x3", 8'h02, 8'h03, 16'h0006);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    checkOutput("done_count", 64'(doneCount), 64'(pushCount));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
